// File: rtl/lp_arith_arbiter_if.sv
// lp_arith_arbiter_if: requester, response and arithmetic-unit signals of the arbiter
interface lp_arith_arbiter_if #(parameter int WIDTH = 8);
  logic               req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [WIDTH-1:0]   req0_a, req0_b;
  logic [1:0]         req0_op;
  logic [2*WIDTH-1:0] rsp0_data;
  logic               req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0]   req1_a, req1_b;
  logic [1:0]         req1_op;
  logic [2*WIDTH-1:0] rsp1_data;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [1:0]         alu_op;
  logic [2*WIDTH-1:0] alu_result;
  logic               busy;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready, alu_result,
    output req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
    output alu_a, alu_b, alu_op, busy
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready, alu_result,
    input  req0_ready, rsp0_valid, rsp0_data, req1_ready, rsp1_valid, rsp1_data,
    input  alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/lp_arith_arbiter.sv
// lp_arith_arbiter: two-requester round-robin sequencer for a gated combinational arithmetic unit
module lp_arith_arbiter #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  lp_arith_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t             state;
  logic               rr_ptr, g, winner, any_valid, rsp_ready_g;
  logic [1:0]         rsp_valid;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [1:0]         sel_op;
  // winner selection and operand mux; rr_ptr only matters when both requesters contend
  always_comb begin
    any_valid   = bus.req0_valid | bus.req1_valid;
    winner      = (bus.req0_valid & bus.req1_valid) ? rr_ptr : bus.req1_valid;
    sel_a       = winner ? bus.req1_a : bus.req0_a;
    sel_b       = winner ? bus.req1_b : bus.req0_b;
    sel_op      = winner ? bus.req1_op : bus.req0_op;
    rsp_ready_g = g ? bus.rsp1_ready : bus.rsp0_ready;
  end
  assign bus.req0_ready = (state == IDLE) && any_valid && !winner;
  assign bus.req1_ready = (state == IDLE) && any_valid && winner;
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_data  = result;
  assign bus.rsp1_data  = result;
  assign bus.busy       = state != IDLE;
  // sequencer: operands reach the unit only for the single ISSUE cycle, gated otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      g         <= 1'b0;
      rsp_valid <= 2'b00;
      result    <= '0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      bus.alu_op <= 2'b11;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          g          <= winner;
          bus.alu_a  <= (sel_op == 2'b11) ? '0 : sel_a;
          bus.alu_b  <= (sel_op == 2'b11) ? '0 : sel_b;
          bus.alu_op <= sel_op;
          state      <= ISSUE;
        end
        ISSUE: begin
          result     <= (bus.alu_op == 2'b11) ? '0 : bus.alu_result;
          bus.alu_a  <= '0;
          bus.alu_b  <= '0;
          bus.alu_op <= 2'b11;
          rsp_valid  <= g ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: if (rsp_ready_g) begin
          rsp_valid <= 2'b00;
          rr_ptr    <= ~g;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lp_arith_arbiter.sv
// tb_lp_arith_arbiter: scoreboard bench for the round-robin arithmetic sequencer
module tb_lp_arith_arbiter;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lp_arith_arbiter_if #(.WIDTH(W)) bus();
  lp_arith_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [2*W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    return op == 2'b00 ? {{W{1'b0}}, a} + {{W{1'b0}}, b} :
           op == 2'b01 ? {{W{1'b0}}, a} - {{W{1'b0}}, b} :
           op == 2'b10 ? {{W{1'b0}}, a} * {{W{1'b0}}, b} : '0;
  endfunction
  assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  int vecs = 0;
  int errs = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ph = 0;
  int nrsp = 0;
  int t_hs = 0;
  logic rr = 1'b0;
  logic gi = 1'b0;
  logic er0, er1;
  logic [W-1:0] ea, eb;
  logic [1:0] eop;
  logic [2*W-1:0] last_rsp = '0;
  logic [2*W-1:0] q[$];
  int glog[$];
  int tacc[$];
  // reference model of the protocol: idle/issue/resp phase, round-robin pointer, result queue
  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
      rr = 1'b0;
      q.delete();
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_alu_op", bus.alu_op, 3);
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
    end else begin
      er0 = ph == 0 && bus.req0_valid && (!bus.req1_valid || !rr);
      er1 = ph == 0 && bus.req1_valid && (!bus.req0_valid || rr);
      chk("req0_ready", bus.req0_ready, er0);
      chk("req1_ready", bus.req1_ready, er1);
      chk("busy", bus.busy, ph != 0);
      chk("rsp0_valid", bus.rsp0_valid, ph == 2 && !gi);
      chk("rsp1_valid", bus.rsp1_valid, ph == 2 && gi);
      chk("alu_op", bus.alu_op, ph == 1 ? eop : 2'b11);
      chk("alu_a", bus.alu_a, (ph == 1 && eop != 2'b11) ? ea : '0);
      chk("alu_b", bus.alu_b, (ph == 1 && eop != 2'b11) ? eb : '0);
      case (ph)
        0: if (er0 || er1) begin
          gi  = er1;
          ea  = gi ? bus.req1_a : bus.req0_a;
          eb  = gi ? bus.req1_b : bus.req0_b;
          eop = gi ? bus.req1_op : bus.req0_op;
          q.push_back(alu_f(ea, eb, eop));
          glog.push_back(int'(gi));
          tacc.push_back(cyc);
          ph = 1;
        end
        1: ph = 2;
        default: begin
          chk("rsp_data", gi ? bus.rsp1_data : bus.rsp0_data, q[0]);
          if (gi ? bus.rsp1_ready : bus.rsp0_ready) begin
            last_rsp = q.pop_front();
            nrsp++;
            rr = ~gi;
            t_hs = cyc;
            ph = 0;
          end
        end
      endcase
    end
  end
  task automatic send(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    bit ok = 0;
    if (idx) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (idx ? bus.req1_ready : bus.req0_ready) begin
        ok = 1;
        break;
      end
    end
    chk("send_timeout", ok, 1);
    @(posedge clk) #1;
    if (idx) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask
  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ph == 0 && q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
    #1;
  endtask
  task automatic wait_grants(input int n);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (glog.size() >= n) begin
        ok = 1;
        break;
      end
    end
    chk("grant_timeout", ok, 1);
    #1;
  endtask
  int n0;
  initial begin
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0; bus.rsp0_ready = 1;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0; bus.rsp1_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("idle_alu_op", bus.alu_op, 3);
    chk("idle_busy", bus.busy, 0);
    @(posedge clk) #1;
    send(1'b0, 8'd200, 8'd100, 2'b00);
    drain();
    chk("add_result", last_rsp, 16'd300);
    chk("add_busy_after", bus.busy, 0);
    send(1'b1, 8'd3, 8'd5, 2'b01);
    drain();
    chk("sub_wrap", last_rsp, 16'hFFFE);
    send(1'b0, 8'd255, 8'd255, 2'b10);
    drain();
    chk("mul_max", last_rsp, 16'hFE01);
    rst_n = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    glog.delete(); tacc.delete();
    bus.req0_a = 8'd10; bus.req0_b = 8'd1; bus.req0_op = 2'b00;
    bus.req1_a = 8'd20; bus.req1_b = 8'd2; bus.req1_op = 2'b01;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    wait_grants(6);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) chk($sformatf("rr_grant%0d", i), glog[i], i % 2);
      if (i > 0 && i < tacc.size()) chk($sformatf("rr_spacing%0d", i), tacc[i] - tacc[i-1], 3);
    end
    send(1'b0, 8'd77, 8'd88, 2'b11);
    drain();
    chk("nop_result", last_rsp, 0);
    bus.rsp0_ready = 1'b0;
    send(1'b0, 8'd9, 8'd4, 2'b10);
    bus.req1_valid = 1'b1; bus.req1_a = 8'd6; bus.req1_b = 8'd7; bus.req1_op = 2'b00;
    n0 = nrsp;
    repeat (12) @(posedge clk);
    chk("bp_held", ph, 2);
    chk("bp_no_rsp", nrsp, n0);
    #1 bus.rsp0_ready = 1'b1;
    n0 = glog.size();
    wait_grants(n0 + 1);
    bus.req1_valid = 1'b0;
    chk("bp_req0_result", last_rsp, 16'd36);
    if (tacc.size() > 0) chk("bp_accept_after_hs", tacc[tacc.size()-1] - t_hs, 1);
    drain();
    chk("bp_req1_result", last_rsp, 16'd13);
    n0 = nrsp;
    send(1'b0, 8'd1, 8'd2, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("issue_rst_busy", bus.busy, 0);
    chk("issue_rst_alu_op", bus.alu_op, 3);
    chk("issue_rst_alu_a", bus.alu_a, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("issue_rst_no_rsp", nrsp, n0);
    bus.rsp0_ready = 1'b0;
    send(1'b0, 8'd5, 8'd6, 2'b00);
    @(posedge clk) #1;
    chk("resp_valid_before_rst", bus.rsp0_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("resp_rst_valid", bus.rsp0_valid, 0);
    chk("resp_rst_busy", bus.busy, 0);
    @(posedge clk) #1 rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("resp_rst_no_rsp", nrsp, n0);
    glog.delete();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    wait_grants(1);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    if (glog.size() > 0) chk("first_grant_after_rst", glog[0], 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/lp_arith_arbiter.md
Name: lp_arith_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared combinational low-power arithmetic unit (add / sub / multiply, `op` 2'b11 = gated idle).
- Accepts operand requests over valid/ready handshakes and registers the operands into the unit.
- Captures the 2*WIDTH result and returns it to the granted requester over a response handshake.
- Holds the unit in its gated state (`op` = 2'b11, operands zero) whenever no operation is in flight.

Parameters:
- WIDTH, 8, operand width; results are 2*WIDTH bits.

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req0_op  in  2  requester 0 op: 00 add, 01 sub, 10 mul, 11 nop
- rsp0_valid  out  1  result available for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_data  out  2*WIDTH  result for requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_ready, rsp1_data  same as requester 0, for requester 1
- alu_a  out  WIDTH  operand a to arithmetic unit
- alu_b  out  WIDTH  operand b to arithmetic unit
- alu_op  out  2  op to arithmetic unit
- alu_result  in  2*WIDTH  combinational result from arithmetic unit
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low), regardless of in-flight work; in-flight operation discarded, no response issued:
  - state=IDLE
  - rr_ptr=0
  - every output register cleared
  - rsp0_valid=rsp1_valid=0
  - alu_a=alu_b=0, alu_op=2'b11
  - busy=0
- FSM states: IDLE, ISSUE, RESP.
- IDLE, winner selection:
  - Only reqN_valid high -> N wins.
  - Both high -> requester rr_ptr wins.
  - reqN_ready = (state==IDLE) && winner==N, combinational. At most one ready high at any time; never high outside IDLE.
- IDLE, on accept:
  - Latch a, b, op and granted index g into internal registers.
  - Go to ISSUE.
  - Neither valid -> stay in IDLE.
- ISSUE (one cycle):
  - alu_a, alu_b and alu_op are registered outputs loaded on the accept edge, so they are stable for the whole ISSUE cycle.
  - At the end of ISSUE, capture alu_result into the result register and go to RESP.
  - Latched op = 11: alu_a/alu_b still loaded with zero, alu_op=11, captured result 0.
- RESP:
  - rsp<g>_valid=1; rsp<g>_data = captured result, held stable until handshake.
  - Non-granted rsp valid=0.
  - On rsp<g>_ready=1: clear valid, set rr_ptr = ~g, go to IDLE.
  - The next accept happens no earlier than the following cycle.
- ALU gating:
  - alu_op forced to 2'b11 and alu_a/alu_b to 0 on the edge leaving ISSUE; they stay gated through RESP and IDLE.
  - No operand toggling reaches the unit outside ISSUE.
- Timing:
  - Latency: accept edge -> rsp valid 2 cycles later (accept edge, ISSUE edge, RESP).
  - Peak throughput: 1 op per 3 cycles with rsp_ready held high.
- Widths:
  - Result is passed through unmodified as 2*WIDTH bits.
  - Subtraction underflow is the unit's 2*WIDTH two's-complement wrap, e.g. 3-5 = 0xFFFE for WIDTH=8; no saturation, no flags.
- Requester rules:
  - Once valid is raised, the requester holds valid and operands until ready.
  - Dropping valid before ready is permitted; the request is simply not taken.
  - The arbiter never samples operands outside the accept cycle.
- Fairness: both requesters continuously valid -> grants strictly alternate 0,1,0,1 starting with 0 after reset.
- Backpressure: rsp_ready held low keeps the block in RESP indefinitely; a new request is never accepted while a result is pending.
- Simultaneous events:
  - A new reqN_valid rising in the same cycle as the RESP handshake is not accepted until the IDLE cycle.
  - Request and response of the same requester may overlap on the bus (valid high during RESP) without effect.

Test Plan:
- Reset -> both ready 0 with no valid, alu_op=11, busy=0. req0 {a=200,b=100,op=00} with rsp0_ready=1 -> req0_ready in accept cycle, alu_op=00 next cycle, rsp0_valid with rsp0_data=300 two cycles after accept, busy=0 afterwards.
- req1 {a=3,b=5,op=01} -> rsp1_data=0xFFFE. req0 {a=255,b=255,op=10} -> rsp0_data=0xFE01.
- Both valid continuously, rsp ready=1 -> grant order 0,1,0,1, one accept every 3 cycles, alu_op=11 in every non-ISSUE cycle.
- req0 op=11 -> alu_a=alu_b=0 and alu_op=11 throughout, rsp0_data=0.
- rsp0_ready low 10 cycles with req1_valid high -> rsp0_data stable, req1_ready stays 0. On release, req1 is accepted the cycle after the handshake.
- rst_n pulsed low during ISSUE and during RESP -> outputs immediately at reset values, no response delivered. First grant after reset goes to requester 0 when both are valid.
